pooling_layer: RTL and testbench
================================

POOLING_LAYER -- requirements
Module: pooling_layer

Interface
REQ-001 The module SHALL have parameter I_WIDTH, default 8: bit width of one channel sample.
REQ-002 The module SHALL have parameter CHANNELS, default 3: channels packed per pixel.
REQ-003 The module SHALL have parameter FILTER_SIZE, default 2: pooling window side length in pixels.
REQ-004 The module SHALL have parameter IMAGE_SIZE, default 64: image width in pixels; the row length of the raster stream.
REQ-005 The module SHALL have parameter STRIDE, default 2: window step, both axes.
REQ-006 The module SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-007 The module SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-008 The module SHALL have port clk_en, input, 1 bit: pixel accept strobe; one input pixel is consumed per rising edge with clk_en=1.
REQ-009 The module SHALL have port input_data, input, CHANNELS*I_WIDTH bits: channel c in bits [c*I_WIDTH +: I_WIDTH].
REQ-010 The module SHALL have port output_data, output, CHANNELS*I_WIDTH bits: pooled pixel, same channel packing.
REQ-011 The module SHALL have port valid, output, 1 bit: one-cycle pulse qualifying output_data.

Function
REQ-012 Input SHALL be a raster stream, row-major, IMAGE_SIZE pixels per row, unbounded row count; column and row position tracked internally.
REQ-013 The module SHALL compute per-channel maximum over each non-overlapping FILTER_SIZE x FILTER_SIZE window; FILTER_SIZE==STRIDE and IMAGE_SIZE divisible by STRIDE are required parameter constraints.
REQ-014 Comparison SHALL be unsigned per channel; channels independent.
REQ-015 Partial window maxima SHALL be kept in a buffer of IMAGE_SIZE/STRIDE entries, reset at the first pixel of each window.
REQ-016 When the bottom-right pixel of a window (col mod STRIDE = STRIDE-1, row mod STRIDE = STRIDE-1) is accepted, output_data SHALL be updated and valid SHALL be 1 on the following cycle (latency 1 clock).
REQ-017 valid SHALL be 0 in every other cycle, including cycles where clk_en=0.
REQ-018 output_data SHALL hold its last value when valid=0.
REQ-019 With clk_en=0, counters and buffer SHALL be frozen; input_data ignored.
REQ-020 Column counter SHALL wrap at IMAGE_SIZE-1 to 0 and advance row; row phase SHALL wrap mod STRIDE, so back-to-back images with height divisible by STRIDE need no reset.
REQ-021 Outputs SHALL appear in raster order of windows; an IMAGE_SIZE x H image yields exactly IMAGE_SIZE*H/STRIDE^2 valid pulses.

Reset
REQ-022 While rst_n=0: valid=0, output_data=0, counters=0, buffer=0, asynchronously.
REQ-023 Reset mid-image SHALL discard partial windows; the first pixel accepted after release is position (row 0, col 0).

Configuration
REQ-024 Macro POOLING_LAYER_SIGNED_EN defined: per-channel comparison SHALL treat samples as two's complement signed, and buffer entries SHALL restart from the incoming pixel (never from 0).
REQ-025 Macro undefined: unsigned comparison per REQ-014.

Verification (I_WIDTH=8, CHANNELS=3, FILTER_SIZE=2, IMAGE_SIZE=64, STRIDE=2)
REQ-026 Reset, stream 64x32 random pixels with clk_en=1 -> exactly 512 valid pulses, each equal to per-channel max of its 2x2 window.
REQ-027 Window pixels 0x010203, 0x0A0000 (row 0), 0x000B00, 0x00000C (row 1) -> output_data=0x0A0B0C with valid one cycle after the row-1 col-1 pixel.
REQ-028 From reset, no valid during row 0; first valid exactly one cycle after pixel index 65 accepted.
REQ-029 clk_en=0 for 5 cycles mid-row -> valid stays 0 throughout, output sequence identical to uninterrupted run.
REQ-030 rst_n pulsed low mid-row 1 -> valid/output_data go 0 immediately; next accepted pixel treated as (0,0).
REQ-031 Channel samples 0x80 vs 0x7F in one window -> 0x80 without POOLING_LAYER_SIGNED_EN, 0x7F with it.

Source files
------------

// File: rtl/pooling_layer.sv
// Streaming max-pooling over non-overlapping STRIDE x STRIDE windows of a raster pixel stream.
// Define POOLING_LAYER_SIGNED_EN to compare channel samples as two's complement signed values.
module pooling_layer #(
  parameter int I_WIDTH     = 8,
  parameter int CHANNELS    = 3,
  parameter int FILTER_SIZE = 2,
  parameter int IMAGE_SIZE  = 64,
  parameter int STRIDE      = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clk_en,
  input  logic [CHANNELS*I_WIDTH-1:0] input_data,
  output logic [CHANNELS*I_WIDTH-1:0] output_data,
  output logic                        valid
);

  localparam int W     = CHANNELS * I_WIDTH;
  localparam int NWIN  = IMAGE_SIZE / STRIDE;
  localparam int WIN_W = (NWIN > 1) ? $clog2(NWIN) : 1;
  localparam int PH_W  = (STRIDE > 1) ? $clog2(STRIDE) : 1;

  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(STRIDE - 1);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(NWIN - 1);

  // FILTER_SIZE must equal STRIDE; the window geometry is driven by STRIDE alone.

  // Position: col_ph = column within window, win_idx = window column, row_ph = row within window.
  logic [PH_W-1:0]  col_ph;
  logic [PH_W-1:0]  row_ph;
  logic [WIN_W-1:0] win_idx;
  logic [W-1:0]     buf_q [NWIN];

  logic         first_px;
  logic         last_px;
  logic [W-1:0] base;
  logic [W-1:0] merged;

  function automatic logic [W-1:0] chan_max(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    r = '0;
    for (int c = 0; c < CHANNELS; c++) begin
`ifdef POOLING_LAYER_SIGNED_EN
      r[c*I_WIDTH +: I_WIDTH] = ($signed(a[c*I_WIDTH +: I_WIDTH]) > $signed(b[c*I_WIDTH +: I_WIDTH]))
                                ? a[c*I_WIDTH +: I_WIDTH] : b[c*I_WIDTH +: I_WIDTH];
`else
      r[c*I_WIDTH +: I_WIDTH] = (a[c*I_WIDTH +: I_WIDTH] > b[c*I_WIDTH +: I_WIDTH])
                                ? a[c*I_WIDTH +: I_WIDTH] : b[c*I_WIDTH +: I_WIDTH];
`endif
    end
    return r;
  endfunction

  always_comb begin
    first_px = (col_ph == '0) && (row_ph == '0);
    last_px  = (col_ph == PH_LAST) && (row_ph == PH_LAST);
`ifdef POOLING_LAYER_SIGNED_EN
    base     = first_px ? input_data : buf_q[win_idx];
`else
    base     = first_px ? '0 : buf_q[win_idx];
`endif
    merged   = chan_max(base, input_data);
  end

  // valid: single-cycle pulse, high only in the cycle after a window's last pixel is accepted;
  // no back-pressure, output_data is stable whenever valid is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_ph      <= '0;
      row_ph      <= '0;
      win_idx     <= '0;
      valid       <= 1'b0;
      output_data <= '0;
      for (int i = 0; i < NWIN; i++) buf_q[i] <= '0;
    end else if (clk_en) begin
      buf_q[win_idx] <= merged;
      valid          <= last_px;
      if (last_px) output_data <= merged;
      if (col_ph == PH_LAST) begin
        col_ph <= '0;
        if (win_idx == WIN_LAST) begin
          win_idx <= '0;
          row_ph  <= (row_ph == PH_LAST) ? '0 : row_ph + 1'b1;
        end else begin
          win_idx <= win_idx + 1'b1;
        end
      end else begin
        col_ph <= col_ph + 1'b1;
      end
    end else begin
      valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pooling_layer.sv
// Self-checking bench for pooling_layer: 2x2 max pooling on a 64-wide 24-bit pixel stream.
module tb_pooling_layer;

  localparam int W  = 24;
  localparam int IS = 64;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         clk_en = 1'b0;
  logic [W-1:0] input_data = '0;
  logic [W-1:0] output_data;
  logic         valid;

  pooling_layer #(.I_WIDTH(8), .CHANNELS(3), .FILTER_SIZE(2), .IMAGE_SIZE(IS), .STRIDE(2)) dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
    .input_data(input_data), .output_data(output_data), .valid(valid)
  );

  // clock/reset block
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // reference model state
  logic [W-1:0] exp_q[$];
  logic [W-1:0] top_row [IS];
  logic [W-1:0] left_px;
  int           m_row, m_col, px_since_rst;
  logic         exp_flag = 1'b0;
  logic         exp_valid_d = 1'b0;
  int           pulses, acc65_cyc, first_cyc;
  logic         first_seen;
  logic [W-1:0] first_data, second_data;

  always @(posedge clk) exp_valid_d <= exp_flag;

  function automatic logic [W-1:0] m_max(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    logic [7:0]   x, y;
    for (int c = 0; c < 3; c++) begin
      x = a[c*8 +: 8];
      y = b[c*8 +: 8];
`ifdef POOLING_LAYER_SIGNED_EN
      r[c*8 +: 8] = ($signed(x) > $signed(y)) ? x : y;
`else
      r[c*8 +: 8] = (x > y) ? x : y;
`endif
    end
    return r;
  endfunction

  // scoreboard / monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (rst_n) begin
      check("valid", {31'b0, valid}, {31'b0, exp_valid_d});
      if (valid) begin
        pulses++;
        if (pulses == 2) second_data = output_data;
        if (!first_seen) begin
          first_seen = 1'b1;
          first_cyc  = cyc;
          first_data = output_data;
        end
        if (exp_q.size() == 0) check("sb_empty", 32'd1, 32'd0);
        else check("data", {8'b0, output_data}, {8'b0, exp_q.pop_front()});
      end
    end
  end

  // driver tasks
  task automatic drive_pixel(input logic [W-1:0] pix);
    input_data = pix;
    clk_en     = 1'b1;
    exp_flag   = (m_row % 2 == 1) && (m_col % 2 == 1);
    if (m_row % 2 == 0) top_row[m_col] = pix;
    else if (m_col % 2 == 0) left_px = pix;
    else exp_q.push_back(m_max(m_max(top_row[m_col-1], top_row[m_col]), m_max(left_px, pix)));
    @(posedge clk);
    #1;
    if (px_since_rst == 65) acc65_cyc = cyc;
    px_since_rst++;
    if (m_col == IS - 1) begin
      m_col = 0;
      m_row++;
    end else begin
      m_col++;
    end
  endtask

  task automatic idle(input int n);
    clk_en   = 1'b0;
    exp_flag = 1'b0;
    input_data = W'($urandom);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    clk_en   = 1'b0;
    exp_flag = 1'b0;
    #1;
    check("rst_valid", {31'b0, valid}, 32'd0);
    check("rst_data", {8'b0, output_data}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    exp_q.delete();
    m_row = 0; m_col = 0; px_since_rst = 0;
    pulses = 0; first_seen = 1'b0;
    rst_n = 1'b1;
  endtask

  function automatic logic [W-1:0] pick(input int r, input int c);
    if (r == 0 && c == 0) return 24'h010203;
    if (r == 0 && c == 1) return 24'h0A0000;
    if (r == 1 && c == 0) return 24'h000B00;
    if (r == 1 && c == 1) return 24'h00000C;
    if (r == 0 && c == 2) return 24'h808080;
    if (r == 0 && c == 3) return 24'h7F7F7F;
    if (r == 1 && c == 2) return 24'h7F7F7F;
    if (r == 1 && c == 3) return 24'h000000;
    return W'($urandom_range(0, 32'hFFFFFF));
  endfunction

  initial begin
    do_reset();

    // full 64x32 frame with a 5-cycle clk_en gap in row 5
    for (int r = 0; r < 32; r++) begin
      for (int c = 0; c < IS; c++) begin
        if (r == 5 && c == 20) idle(5);
        drive_pixel(pick(r, c));
      end
    end
    idle(3);
    check("pulses_frame", pulses, 512);
    check("first_lat", first_cyc, acc65_cyc);
    check("first_data", {8'b0, first_data}, 32'h0A0B0C);
`ifdef POOLING_LAYER_SIGNED_EN
    check("sign_cmp", {8'b0, second_data}, 32'h7F7F7F);
`else
    check("sign_cmp", {8'b0, second_data}, 32'h808080);
`endif

    // back-to-back frame, then reset mid row 1 right after a window completes
    for (int i = 0; i < IS + 12; i++) drive_pixel(W'($urandom));
    check("pre_rst_valid", {31'b0, valid}, 32'd1);
    do_reset();

    // after release the stream restarts at (0,0)
    for (int i = 0; i < 2 * IS; i++) drive_pixel(W'($urandom));
    idle(3);
    check("pulses_after_rst", pulses, 32);
    check("sb_left", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
